// File: rtl/pairwise_pkg.sv
// Shared definitions for the pairwise gate pipeline: op encoding and the
// single-bit gate function applied to each neighbouring pair of operand bits.
package pairwise_pkg;

    // Encoding of the in_op / out_op field
    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XNOR = 2'd2,
        OP_XOR  = 2'd3
    } pairwise_op_t;

    // Apply one gate to a pair of bits
    function automatic logic pairwise_op(input pairwise_op_t op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XNOR: r = ~(a ^ b);
            OP_XOR:  r = a ^ b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready pipeline register: loads when it is empty or its consumer
// is draining it, otherwise holds its contents.
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // The stage can take new data when empty or when its content leaves this cycle
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Next-state: load on accept, go empty when drained, hold otherwise
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Stage register; reset empties the stage and zeroes its data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pairwise_gates_pipe.sv
// Two-stage pipeline applying a gate to each neighbouring bit pair of the
// operand word. S1 holds {op, operand}; the gates and popcount are evaluated
// between S1 and S2, and S2 holds {op, popcount, result}.
module pairwise_gates_pipe
    import pairwise_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int WRAP  = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [NBITS-1:0]         in_,
    input  logic [1:0]               in_op,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [NBITS-1:0]         out_,
    output logic [$clog2(NBITS)+1-1:0] out_cnt,
    output logic [1:0]               out_op,
    output logic [15:0]              txn_cnt
);

    localparam int CW  = $clog2(NBITS) + 1;
    localparam int S1W = NBITS + 2;
    localparam int S2W = NBITS + CW + 2;

    if (NBITS < 2) begin : g_bad_nbits
        $error("pairwise_gates_pipe: NBITS must be at least 2");
    end

    logic               s1_valid;
    logic [S1W-1:0]     s1_data;
    logic               s2_in_ready;
    logic [S2W-1:0]     s2_data;
    pairwise_op_t       s1_op;
    logic [NBITS-1:0]   s1_word;
    logic [NBITS-1:0]   gate_res;
    logic [CW-1:0]      gate_cnt;
    logic [15:0]        txn_cnt_q;
    logic [15:0]        txn_cnt_d;

    // Operand register: captures the op and the operand word
    pipe_stage #(
        .W(S1W)
    ) u_s1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_val),
        .in_ready (in_rdy),
        .in_data  ({in_op, in_}),
        .out_valid(s1_valid),
        .out_ready(s2_in_ready),
        .out_data (s1_data)
    );

    assign s1_op   = pairwise_op_t'(s1_data[S1W-1 -: 2]);
    assign s1_word = s1_data[NBITS-1:0];

    // Gate each neighbouring pair; the top bit either wraps to bit 0 or is forced low
    always_comb begin
        gate_res = '0;
        for (int i = 0; i < NBITS - 1; i++) begin
            gate_res[i] = pairwise_op(s1_op, s1_word[i], s1_word[i+1]);
        end
        if (WRAP != 0) begin
            gate_res[NBITS-1] = pairwise_op(s1_op, s1_word[NBITS-1], s1_word[0]);
        end
    end

    // Popcount of the gate result, registered alongside it so both share timing
    always_comb begin
        gate_cnt = '0;
        for (int i = 0; i < NBITS; i++) begin
            gate_cnt = gate_cnt + {{(CW-1){1'b0}}, gate_res[i]};
        end
    end

    // Result register: holds {op, popcount, result} until the consumer takes it
    pipe_stage #(
        .W(S2W)
    ) u_s2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (s1_valid),
        .in_ready (s2_in_ready),
        .in_data  ({s1_data[S1W-1 -: 2], gate_cnt, gate_res}),
        .out_valid(out_val),
        .out_ready(out_rdy),
        .out_data (s2_data)
    );

    assign out_    = s2_data[NBITS-1:0];
    assign out_cnt = s2_data[NBITS+CW-1:NBITS];
    assign out_op  = s2_data[S2W-1 -: 2];

    // Count completed output transfers; wraps naturally at 16 bits
    always_comb begin
        txn_cnt_d = txn_cnt_q;
        if (out_val && out_rdy) begin
            txn_cnt_d = txn_cnt_q + 16'd1;
        end
    end

    // Transfer counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txn_cnt_q <= 16'd0;
        end else begin
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_pairwise_gates_pipe.sv
// Scoreboard bench: two NBITS=4 instances (WRAP=0 and WRAP=1) share stimulus;
// expected results are queued on accept and compared on each output transfer.
module tb_pairwise_gates_pipe;

    logic        clk;
    logic        reset_n;
    logic        in_val;
    logic [3:0]  in_;
    logic [1:0]  in_op;
    logic        out_rdy;

    logic        in_rdy0, in_rdy1;
    logic        out_val0, out_val1;
    logic [3:0]  out0, out1;
    logic [2:0]  cnt0, cnt1;
    logic [1:0]  op0, op1;
    logic [15:0] txn0, txn1;

    typedef struct {
        logic [3:0] d;
        logic [1:0] op;
        logic [3:0] r0;
        logic [3:0] r1;
        int         cyc;
        bit         lat;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_txn = 16'd0;
    bit          lat_check = 1'b0;

    pairwise_gates_pipe #(.NBITS(4), .WRAP(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy0),
        .in_(in_), .in_op(in_op), .out_val(out_val0), .out_rdy(out_rdy),
        .out_(out0), .out_cnt(cnt0), .out_op(op0), .txn_cnt(txn0)
    );

    pairwise_gates_pipe #(.NBITS(4), .WRAP(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy1),
        .in_(in_), .in_op(in_op), .out_val(out_val1), .out_rdy(out_rdy),
        .out_(out1), .out_cnt(cnt1), .out_op(op1), .txn_cnt(txn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference gate model for a 4-bit word
    function automatic logic [3:0] model(input logic [3:0] a, input logic [1:0] op, input bit wrap);
        logic [3:0] r;
        logic x, y;
        r = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && !wrap) begin
                r[i] = 1'b0;
            end else begin
                x = a[i];
                y = a[(i + 1) % 4];
                case (op)
                    2'd0:    r[i] = x & y;
                    2'd1:    r[i] = x | y;
                    2'd2:    r[i] = ~(x ^ y);
                    default: r[i] = x ^ y;
                endcase
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Offer one input and hold it until accepted (bounded)
    task automatic applyStimulus(input logic [3:0] d, input logic [1:0] op);
        bit acc;
        in_val = 1'b1;
        in_    = d;
        in_op  = op;
        acc    = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_rdy0;
            @(posedge clk);
            #1;
        end
        if (!acc) checkOutput("accept_timeout", {31'd0, in_rdy0}, 32'd1);
        in_val = 1'b0;
    endtask

    // Wait until every queued result has been delivered (bounded)
    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 32'd0);
    endtask

    // Monitor: push on accept, pop and compare on delivery, track txn_cnt
    always @(negedge clk) begin
        sb_entry_t e;
        cyc++;
        if (!reset_n) begin
            sb.delete();
            exp_txn = 16'd0;
        end else begin
            checkOutput("txn_cnt", {16'd0, txn0}, {16'd0, exp_txn});
            if (out_val0 && out_rdy) begin
                if (sb.size() == 0) begin
                    checkOutput("stale_out", {31'd0, out_val0}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_w0", {28'd0, out0}, {28'd0, e.r0});
                    checkOutput("cnt_w0", {29'd0, cnt0}, $countones(e.r0));
                    checkOutput("op_w0", {30'd0, op0}, {30'd0, e.op});
                    checkOutput("val_w1", {31'd0, out_val1}, 32'd1);
                    checkOutput("out_w1", {28'd0, out1}, {28'd0, e.r1});
                    checkOutput("cnt_w1", {29'd0, cnt1}, $countones(e.r1));
                    if (e.lat && lat_check) checkOutput("latency", cyc - e.cyc, 32'd2);
                end
                exp_txn = exp_txn + 16'd1;
            end
            if (in_val && in_rdy0) begin
                e.d   = in_;
                e.op  = in_op;
                e.r0  = model(in_, in_op, 1'b0);
                e.r1  = model(in_, in_op, 1'b1);
                e.cyc = cyc;
                e.lat = lat_check;
                sb.push_back(e);
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] vec [3];
        logic [1:0] ops [3];
        int         idx;
        int         accepts;
        bit         acc;

        reset_n = 1'b0;
        in_val  = 1'b0;
        in_     = 4'd0;
        in_op   = 2'd0;
        out_rdy = 1'b1;
        #2;
        checkOutput("rst_out_val", {31'd0, out_val0}, 32'd0);
        checkOutput("rst_in_rdy", {31'd0, in_rdy0}, 32'd1);
        checkOutput("rst_out", {28'd0, out0}, 32'd0);
        checkOutput("rst_cnt", {29'd0, cnt0}, 32'd0);
        checkOutput("rst_op", {30'd0, op0}, 32'd0);
        checkOutput("rst_txn", {16'd0, txn0}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        checkOutput("rdy_after_rst", {31'd0, in_rdy0}, 32'd1);
        lat_check = 1'b1;

        $display("[TB] single AND on 1011");
        applyStimulus(4'b1011, 2'd0);
        drain();
        @(posedge clk);
        #1;
        checkOutput("txn_first", {16'd0, txn0}, 32'd1);

        $display("[TB] OR/XNOR/XOR back to back");
        applyStimulus(4'b1011, 2'd1);
        applyStimulus(4'b1011, 2'd2);
        applyStimulus(4'b1011, 2'd3);
        drain();

        $display("[TB] pattern sweep");
        for (int p = 0; p < 4; p++) begin
            for (int o = 0; o < 4; o++) begin
                applyStimulus(4'(p * 5 + 3 * o), 2'(o));
            end
        end
        drain();

        $display("[TB] backpressure");
        lat_check = 1'b0;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        vec[0] = 4'b1100; ops[0] = 2'd1;
        vec[1] = 4'b0101; ops[1] = 2'd3;
        vec[2] = 4'b1110; ops[2] = 2'd0;
        idx = 0;
        accepts = 0;
        in_val = 1'b1;
        in_    = vec[0];
        in_op  = ops[0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            acc = in_val && in_rdy0;
            if (acc) accepts++;
            if (out_val0) begin
                checkOutput("bp_hold_out", {28'd0, out0}, {28'd0, model(vec[0], ops[0], 1'b0)});
                checkOutput("bp_hold_cnt", {29'd0, cnt0}, $countones(model(vec[0], ops[0], 1'b0)));
                checkOutput("bp_hold_op", {30'd0, op0}, {30'd0, ops[0]});
            end
            @(posedge clk);
            #1;
            if (acc && idx < 2) begin
                idx++;
                in_   = vec[idx];
                in_op = ops[idx];
            end
        end
        @(negedge clk);
        checkOutput("bp_accepts", accepts, 32'd2);
        checkOutput("bp_in_rdy", {31'd0, in_rdy0}, 32'd0);
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        applyStimulus(vec[2], ops[2]);
        drain();

        $display("[TB] reset with both stages full");
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        applyStimulus(4'b0110, 2'd3);
        applyStimulus(4'b1101, 2'd0);
        @(negedge clk);
        checkOutput("full_in_rdy", {31'd0, in_rdy0}, 32'd0);
        checkOutput("full_out_val", {31'd0, out_val0}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_val", {31'd0, out_val0}, 32'd0);
        checkOutput("mid_rst_out_val_w1", {31'd0, out_val1}, 32'd0);
        checkOutput("mid_rst_in_rdy", {31'd0, in_rdy0}, 32'd1);
        checkOutput("mid_rst_txn", {16'd0, txn0}, 32'd0);
        checkOutput("mid_rst_out", {28'd0, out0}, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkOutput("rel_in_rdy", {31'd0, in_rdy0}, 32'd1);
        out_rdy = 1'b1;
        lat_check = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("no_stale_val", {31'd0, out_val0}, 32'd0);
        end

        $display("[TB] 65537 transfers for counter wrap");
        @(posedge clk);
        #1;
        for (int n = 0; n < 65537; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
        drain();
        @(posedge clk);
        #1;
        checkOutput("txn_wrap", {16'd0, txn0}, 32'd1);
        checkOutput("txn_wrap_w1", {16'd0, txn1}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pairwise_gates_pipe.md
PAIRWISE_GATES_PIPE -- requirements
Module: pairwise_gates_pipe

Interface
REQ-001 SHALL have parameter NBITS, default 8, input word width (legal >= 2).
REQ-002 SHALL have parameter WRAP, default 0, 1 = add the wrap pair (in_[NBITS-1], in_[0]).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_val  input  1  input transaction valid.
REQ-006 SHALL have port in_rdy  output  1  block can accept input this cycle.
REQ-007 SHALL have port in_  input  NBITS  operand word.
REQ-008 SHALL have port in_op  input  2  op select: 0 AND, 1 OR, 2 XNOR, 3 XOR.
REQ-009 SHALL have port out_val  output  1  result valid.
REQ-010 SHALL have port out_rdy  input  1  consumer accepts result.
REQ-011 SHALL have port out_  output  NBITS  pairwise result word.
REQ-012 SHALL have port out_cnt  output  $clog2(NBITS)+1  popcount of out_.
REQ-013 SHALL have port out_op  output  2  op echoed from the accepted input.
REQ-014 SHALL have port txn_cnt  output  16  count of completed output transfers.

Function
REQ-015 SHALL accept an input when in_val && in_rdy, and SHALL deliver a result when out_val && out_rdy.
REQ-016 SHALL be a 2-stage pipeline (S1 operand register, S2 result register); result is presented on out_ 2 cycles after acceptance when there is no backpressure.
REQ-017 SHALL compute out_[i] = op(in_[i], in_[i+1]) for i in 0..NBITS-2.
REQ-018 SHALL drive out_[NBITS-1] = op(in_[NBITS-1], in_[0]) when WRAP=1, and 0 when WRAP=0.
REQ-019 SHALL compute the gate result in S1->S2 logic; out_cnt SHALL be the popcount of the registered out_ and SHALL share its timing.
REQ-020 SHALL make each stage hold its contents while it is valid and its downstream is not ready; stage ready = !stage_valid || downstream_ready.
REQ-021 SHALL drive in_rdy = !S1_valid || S2_ready, with S2_ready = !out_val || out_rdy (full throughput: 1 transfer/cycle when out_rdy is held at 1).
REQ-022 SHALL keep out_, out_cnt and out_op stable while out_val=1 and out_rdy=0.
REQ-023 SHALL allow a simultaneous accept and deliver in one cycle without loss or duplication.
REQ-024 SHALL increment txn_cnt by 1 on each output transfer and wrap from 16'hFFFF to 0.
REQ-025 SHALL ignore in_ and in_op when in_val=0 (no state change).

Reset
REQ-026 SHALL, on reset_n=0 and asynchronously, clear S1_valid, out_val and txn_cnt, and set out_, out_cnt and out_op to 0.
REQ-027 SHALL drive in_rdy=1 while reset_n=0 and in the first cycle after release.
REQ-028 SHALL drop any in-flight transaction on reset mid-operation; no result is emitted after reset for it.

Structure
REQ-029 SHALL take the op encoding (enum pairwise_op_t: AND/OR/XNOR/XOR) from the shared package pairwise_pkg, together with the function computing one pairwise op.
REQ-030 SHALL instantiate one sub-module, pipe_stage (parametrised-width data register with valid and ready-propagation), twice.
REQ-031 SHALL check NBITS >= 2 at elaboration.

Verification
REQ-032 SHALL cover: NBITS=4, WRAP=0, in_=4'b1011, op AND, out_rdy=1 -> 2 cycles later out_=4'b0001, out_cnt=1, txn_cnt=1.
REQ-033 SHALL cover: same in_ with op OR, XNOR and XOR back-to-back -> out_ = 0111/0001/0110, out_cnt = 3/1/2, on consecutive cycles.
REQ-034 SHALL cover: WRAP=1, in_=4'b1011, op AND -> out_=4'b1001, out_cnt=2.
REQ-035 SHALL cover: out_rdy=0 for 5 cycles with 3 inputs offered -> exactly 2 accepted, in_rdy=0 thereafter, out_ stable; on release, results drain in order with no loss.
REQ-036 SHALL cover: 65537 transfers -> txn_cnt=1 (wrap).
REQ-037 SHALL cover: reset_n asserted while both stages are valid -> out_val=0 immediately, txn_cnt=0, in_rdy=1, no stale output after release.
